kmc_npr: RTL and testbench
==========================

# kmc_npr

KMC11 NPR (DMA) controller. Holds the microcode-visible NPR address, data and control registers (NPRIA, NPROA, NPRID, NPROD, NPRC). Runs the bus request/acknowledge sequence for single-word or single-byte memory transfers. Sits directly upstream of the KMC11 data multiplexor, which reads these registers as IBUS/IBUSS sources; the microcode writes them from the ALU output bus.

## Interface
- NXM_TIMEOUT, 127: cycles to wait for dmaACK before declaring non-existent memory (range 2..255).
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- kmcOBUS  in  8  write data from ALU output bus
- kmcOWR  in  1  register write strobe (one cycle)
- kmcOSEL  in  3  write select: 0 NPRODL, 1 NPRODH, 2 NPRIAL, 3 NPRIAH, 4 NPROAL, 5 NPROAH, 6 NPRC, 7 no-op
- kmcNPRID  out  16  NPR in data (read-only to microcode)
- kmcNPROD  out  16  NPR out data
- kmcNPRIA  out  16  NPR in address
- kmcNPROA  out  16  NPR out address
- kmcNPRC  out  8  NPR control register
- dmaREQ  out  1  bus transfer request
- dmaACK  in  1  bus transfer complete (one cycle; dmaDATAI valid when high)
- dmaWRITE  out  1  1 = write memory (out), 0 = read (in)
- dmaBYTE  out  1  byte transfer
- dmaHOLD  out  1  keep bus after this transfer (NPRC[7])
- dmaADDR  out  18  {NPRC[3:2], selected 16-bit address}
- dmaDATAO  out  16  kmcNPROD
- dmaDATAI  in  16  read data

## Operation
- NPRC bits: [0] GO (set by microcode, cleared by hardware), [1] OUT direction, [3:2] address bits 17:16, [4] BYTE, [5] NXM (sticky), [6] reads 0, [7] NOT LAST XFER.
- States: IDLE, REQ.
- IDLE: kmcOWR with kmcOSEL 0–5 loads the addressed byte; other byte is unchanged. OSEL 6 loads NPRC[7:0] with bit 6 forced 0. A write of NPRC with bit0=1 enters REQ next cycle and clears the timeout counter.
- REQ:
  - dmaREQ=1.
  - dmaWRITE=NPRC[1], dmaBYTE=NPRC[4].
  - dmaADDR[15:0]=NPROA if OUT, else NPRIA.
  - Counter increments each cycle.
  - dmaACK=1: if IN, load NPRID<=dmaDATAI (full word; byte-lane selection belongs to the bus). Clear GO, go to IDLE.
  - Counter reaches NXM_TIMEOUT-1 without ACK: set NXM, clear GO, NPRID unchanged, go to IDLE.
  - ACK and timeout in the same cycle: ACK wins, NXM not set.
- All kmcOWR writes are ignored while in REQ; registers are frozen during a transfer.
- NXM is cleared only by an NPRC write with bit5=0, or by reset. An NPRC write with bit5=1 leaves NXM as it was.
- Address registers do not auto-increment.
- dmaHOLD=NPRC[7] in all states.
- dmaADDR, dmaWRITE and dmaBYTE are driven continuously from the registers. They are meaningful only while dmaREQ=1.

## Timing
- Reset: all registers 0, state IDLE, counter 0. So dmaREQ=0, dmaHOLD=0, dmaADDR=0, and all kmc* outputs are 0.
- Register write at edge N is visible on outputs after edge N (one-cycle write latency).
- GO written at edge N: dmaREQ=1 from N to the completing edge.
- ACK sampled at edge M: from M, dmaREQ=0, NPRC[0]=0 and NPRID holds the new data. Minimum transfer is 2 cycles when ACK arrives in the first REQ cycle.
- Timeout: with no ACK, dmaREQ is high for exactly NXM_TIMEOUT cycles. Then NPRC[0]=0 and NPRC[5]=1.
- dmaACK while IDLE is ignored.
- rst asserted mid-transfer: return to IDLE next edge, dmaREQ=0, all registers cleared, no NXM.
- Write strobe coincident with ACK: ignored, because the block is still in REQ on that edge.
- A new GO may be written on the cycle after completion.

## Test plan
- Reset: assert rst, with stimulus active on the inputs -> every output is 0, dmaREQ=0.
- Word in:
  - Load NPRIA=0o1234 via OSEL 2/3, then NPRC=0x0D (GO, IN, ext=3).
  - -> dmaADDR=0x3029C, dmaWRITE=0, dmaBYTE=0.
  - ACK after 3 cycles with dmaDATAI=0xBEEF -> NPRID=0xBEEF, NPRC=0x0C, dmaREQ low next cycle.
- Byte out:
  - Load NPROD=0x5AA5 and NPROA=0x0101, then NPRC=0x93.
  - -> dmaWRITE=1, dmaBYTE=1, dmaHOLD=1, dmaDATAO=0x5AA5, dmaADDR=0x00101.
  - ACK -> NPRC=0x92.
- NXM:
  - GO with no ACK -> dmaREQ high exactly NXM_TIMEOUT cycles, then NPRC[5]=1, NPRC[0]=0.
  - Write NPRC=0x00 -> NXM cleared.
  - Also ACK on the final timeout cycle -> NXM=0.
- Busy protection: during REQ, write NPRIAL=0xFF and NPRC=0x00 -> both ignored, transfer completes with the original address and direction.
- Reset mid-transfer: rst on the 2nd REQ cycle -> dmaREQ=0 next cycle, NPRC=0; a late dmaACK has no effect.

Source files
------------

// File: rtl/kmc_npr_if.sv
// DMA bus side of the KMC11 NPR controller: request/ack handshake, address and data.
// The controller drives the request group (master); the bus returns ack and read data (slave).
interface kmc_npr_if;
  logic        dmaREQ;
  logic        dmaACK;
  logic        dmaWRITE;
  logic        dmaBYTE;
  logic        dmaHOLD;
  logic [17:0] dmaADDR;
  logic [15:0] dmaDATAO;
  logic [15:0] dmaDATAI;

  modport master (
    output dmaREQ, dmaWRITE, dmaBYTE, dmaHOLD, dmaADDR, dmaDATAO,
    input  dmaACK, dmaDATAI
  );

  modport slave (
    input  dmaREQ, dmaWRITE, dmaBYTE, dmaHOLD, dmaADDR, dmaDATAO,
    output dmaACK, dmaDATAI
  );
endinterface

// File: rtl/kmc_npr.sv
// KMC11 NPR controller: microcode-written address/data/control registers plus a
// single-transfer bus request sequencer with a non-existent-memory timeout.
module kmc_npr #(
  parameter int NXM_TIMEOUT = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  kmcOBUS,
  input  logic        kmcOWR,
  input  logic [2:0]  kmcOSEL,
  output logic [15:0] kmcNPRID,
  output logic [15:0] kmcNPROD,
  output logic [15:0] kmcNPRIA,
  output logic [15:0] kmcNPROA,
  output logic [7:0]  kmcNPRC,
  kmc_npr_if.master   dma
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(NXM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] nprid_q, nprid_d;
  logic [15:0] nprod_q, nprod_d;
  logic [15:0] npria_q, npria_d;
  logic [15:0] nproa_q, nproa_d;
  logic [7:0]  nprc_q,  nprc_d;
  logic [7:0]  cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    nprid_d = nprid_q;
    nprod_d = nprod_q;
    npria_d = npria_q;
    nproa_d = nproa_q;
    nprc_d  = nprc_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (kmcOWR) begin
          case (kmcOSEL)
            3'd0: nprod_d[7:0]  = kmcOBUS;
            3'd1: nprod_d[15:8] = kmcOBUS;
            3'd2: npria_d[7:0]  = kmcOBUS;
            3'd3: npria_d[15:8] = kmcOBUS;
            3'd4: nproa_d[7:0]  = kmcOBUS;
            3'd5: nproa_d[15:8] = kmcOBUS;
            3'd6: begin
              // NXM is sticky: writing 1 keeps it, only writing 0 clears it.
              nprc_d = {kmcOBUS[7], 1'b0, kmcOBUS[5] & nprc_q[5], kmcOBUS[4:0]};
              if (kmcOBUS[0]) begin
                state_d = ST_REQ;
                cnt_d   = 8'd0;
              end
            end
            default: ;
          endcase
        end
      end

      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // ACK takes priority over a timeout landing on the same edge.
        if (dma.dmaACK) begin
          if (!nprc_q[1]) nprid_d = dma.dmaDATAI;
          nprc_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          nprc_d[5] = 1'b1;
          nprc_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      nprid_q <= 16'd0;
      nprod_q <= 16'd0;
      npria_q <= 16'd0;
      nproa_q <= 16'd0;
      nprc_q  <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      nprid_q <= nprid_d;
      nprod_q <= nprod_d;
      npria_q <= npria_d;
      nproa_q <= nproa_d;
      nprc_q  <= nprc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign kmcNPRID = nprid_q;
  assign kmcNPROD = nprod_q;
  assign kmcNPRIA = npria_q;
  assign kmcNPROA = nproa_q;
  assign kmcNPRC  = nprc_q;

  assign dma.dmaREQ   = (state_q == ST_REQ);
  assign dma.dmaWRITE = nprc_q[1];
  assign dma.dmaBYTE  = nprc_q[4];
  assign dma.dmaHOLD  = nprc_q[7];
  assign dma.dmaADDR  = {nprc_q[3:2], nprc_q[1] ? nproa_q : npria_q};
  assign dma.dmaDATAO = nprod_q;

endmodule

// File: tb/tb_kmc_npr.sv
// Directed bench for kmc_npr: per-cycle comparison against a transaction-level model
// plus literal checks taken from hand-worked register values.
module tb_kmc_npr;
  localparam int T = 127;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  kmcOBUS = 8'd0;
  logic        kmcOWR = 1'b0;
  logic [2:0]  kmcOSEL = 3'd0;
  logic [15:0] kmcNPRID, kmcNPROD, kmcNPRIA, kmcNPROA;
  logic [7:0]  kmcNPRC;

  kmc_npr_if bus ();

  kmc_npr #(.NXM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .kmcOBUS(kmcOBUS), .kmcOWR(kmcOWR), .kmcOSEL(kmcOSEL),
    .kmcNPRID(kmcNPRID), .kmcNPROD(kmcNPROD), .kmcNPRIA(kmcNPRIA),
    .kmcNPROA(kmcNPROA), .kmcNPRC(kmcNPRC),
    .dma(bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: byte array of registers, a busy flag and cycles left.
  logic [7:0]  m_reg [0:5];
  logic [7:0]  m_nprc  = 8'd0;
  logic [15:0] m_nprid = 16'd0;
  bit          m_busy  = 1'b0;
  int          m_left  = 0;

  initial for (int i = 0; i < 6; i++) m_reg[i] = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) m_reg[i] = 8'd0;
      m_nprc = 8'd0; m_nprid = 16'd0; m_busy = 1'b0; m_left = 0;
    end else if (m_busy) begin
      if (bus.dmaACK) begin
        if (!m_nprc[1]) m_nprid = bus.dmaDATAI;
        m_nprc[0] = 1'b0;
        m_busy = 1'b0;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_nprc[5] = 1'b1;
          m_nprc[0] = 1'b0;
          m_busy = 1'b0;
        end
      end
    end else if (kmcOWR) begin
      if (kmcOSEL < 3'd6) m_reg[kmcOSEL] = kmcOBUS;
      else if (kmcOSEL == 3'd6) begin
        m_nprc = {kmcOBUS[7], 1'b0, (kmcOBUS[5] ? m_nprc[5] : 1'b0), kmcOBUS[4:0]};
        if (kmcOBUS[0]) begin
          m_busy = 1'b1;
          m_left = T;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [15:0] ea;
      ea = m_nprc[1] ? {m_reg[5], m_reg[4]} : {m_reg[3], m_reg[2]};
      chk("model_req",   {31'd0, bus.dmaREQ}, {31'd0, m_busy});
      chk("model_nprc",  {24'd0, kmcNPRC}, {24'd0, m_nprc});
      chk("model_nprid", {16'd0, kmcNPRID}, {16'd0, m_nprid});
      chk("model_nprod", {16'd0, kmcNPROD}, {16'd0, m_reg[1], m_reg[0]});
      chk("model_npria", {16'd0, kmcNPRIA}, {16'd0, m_reg[3], m_reg[2]});
      chk("model_nproa", {16'd0, kmcNPROA}, {16'd0, m_reg[5], m_reg[4]});
      chk("model_addr",  {14'd0, bus.dmaADDR}, {14'd0, m_nprc[3:2], ea});
      chk("model_ctl",   {29'd0, bus.dmaWRITE, bus.dmaBYTE, bus.dmaHOLD},
                         {29'd0, m_nprc[1], m_nprc[4], m_nprc[7]});
      chk("model_datao", {16'd0, bus.dmaDATAO}, {16'd0, m_reg[1], m_reg[0]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] val);
    kmcOWR = 1'b1; kmcOSEL = sel; kmcOBUS = val;
    step();
    kmcOWR = 1'b0;
  endtask

  task automatic ack(input logic [15:0] d);
    bus.dmaACK = 1'b1; bus.dmaDATAI = d;
    step();
    bus.dmaACK = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.dmaACK = 1'b0;
    bus.dmaDATAI = 16'd0;

    // Reset with busy-looking stimulus on every input.
    rst = 1'b1; kmcOWR = 1'b1; kmcOSEL = 3'd6; kmcOBUS = 8'hFF;
    bus.dmaACK = 1'b1; bus.dmaDATAI = 16'hFFFF;
    step(); step();
    chk("rst_req",  {31'd0, bus.dmaREQ}, 32'd0);
    chk("rst_outs", {kmcNPRC, kmcNPRID, 8'd0} | {16'd0, kmcNPRIA} | {kmcNPROA, kmcNPROD}, 32'd0);
    chk("rst_dma",  {12'd0, bus.dmaHOLD, bus.dmaADDR, bus.dmaWRITE}, 32'd0);
    rst = 1'b0; kmcOWR = 1'b0; kmcOSEL = 3'd0; kmcOBUS = 8'd0;
    bus.dmaACK = 1'b0; bus.dmaDATAI = 16'd0;
    step();
    chk_on = 1'b1;

    // Word in from 0o1234 with extension bits 3.
    wr(3'd2, 8'h9C); wr(3'd3, 8'h02); wr(3'd6, 8'h0D);
    chk("win_addr", {14'd0, bus.dmaADDR}, 32'h3029C);
    chk("win_wb",   {30'd0, bus.dmaWRITE, bus.dmaBYTE}, 32'd0);
    step(); step();
    ack(16'hBEEF);
    chk("win_nprid", {16'd0, kmcNPRID}, 32'hBEEF);
    chk("win_nprc",  {24'd0, kmcNPRC}, 32'h0C);
    chk("win_req",   {31'd0, bus.dmaREQ}, 32'd0);
    chk("win_model_nprc", {24'd0, m_nprc}, 32'h0C);

    // Byte out with hold.
    wr(3'd0, 8'hA5); wr(3'd1, 8'h5A); wr(3'd4, 8'h01); wr(3'd5, 8'h01); wr(3'd6, 8'h93);
    chk("bout_ctl",   {29'd0, bus.dmaWRITE, bus.dmaBYTE, bus.dmaHOLD}, 32'h7);
    chk("bout_datao", {16'd0, bus.dmaDATAO}, 32'h5AA5);
    chk("bout_addr",  {14'd0, bus.dmaADDR}, 32'h00101);
    ack(16'h1111);
    chk("bout_nprc",  {24'd0, kmcNPRC}, 32'h92);
    chk("bout_nprid", {16'd0, kmcNPRID}, 32'hBEEF);

    // NXM timeout: count request cycles.
    wr(3'd6, 8'h01);
    cnt = 0;
    while (bus.dmaREQ && cnt < 400) begin
      cnt++;
      step();
    end
    chk("nxm_len",  cnt, T);
    chk("nxm_nprc", {24'd0, kmcNPRC}, 32'h20);
    chk("nxm_model_nprc", {24'd0, m_nprc}, 32'h20);
    wr(3'd6, 8'h20);
    chk("nxm_keep", {24'd0, kmcNPRC}, 32'h20);
    wr(3'd6, 8'h00);
    chk("nxm_clr",  {24'd0, kmcNPRC}, 32'h00);

    // ACK on the last timeout cycle wins.
    wr(3'd6, 8'h01);
    repeat (T - 1) step();
    chk("late_req", {31'd0, bus.dmaREQ}, 32'd1);
    ack(16'h1234);
    chk("late_nprc",  {24'd0, kmcNPRC}, 32'h00);
    chk("late_nprid", {16'd0, kmcNPRID}, 32'h1234);

    // Writes during a transfer and on the ACK edge are dropped.
    wr(3'd6, 8'h05);
    wr(3'd2, 8'hFF);
    wr(3'd6, 8'h00);
    chk("busy_addr", {14'd0, bus.dmaADDR}, 32'h1029C);
    kmcOWR = 1'b1; kmcOSEL = 3'd3; kmcOBUS = 8'h77;
    ack(16'h4321);
    kmcOWR = 1'b0;
    chk("busy_npria", {16'd0, kmcNPRIA}, 32'h029C);
    chk("busy_nprc",  {24'd0, kmcNPRC}, 32'h04);
    chk("busy_nprid", {16'd0, kmcNPRID}, 32'h4321);

    // Back-to-back GO, out direction.
    wr(3'd6, 8'h03);
    chk("b2b_addr", {14'd0, bus.dmaADDR}, 32'h00101);
    ack(16'h9999);
    chk("b2b_nprid", {16'd0, kmcNPRID}, 32'h4321);

    // Reset on the second request cycle, then a stray ACK.
    wr(3'd6, 8'h01);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req",  {31'd0, bus.dmaREQ}, 32'd0);
    chk("mrst_nprc", {24'd0, kmcNPRC}, 32'd0);
    ack(16'hDEAD);
    chk("mrst_nprid", {16'd0, kmcNPRID}, 32'd0);
    chk("mrst_req2",  {31'd0, bus.dmaREQ}, 32'd0);
    step();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
